// File: rtl/wb_port_arbiter_if.sv
// Write-port bundle between the ALU/load requesters and the write-back arbiter.
// The master side drives the requests; the slave side is the arbiter.
interface wb_port_arbiter_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
);
    logic          ALU_VALID;
    logic          ALU_READY;
    logic [AW-1:0] ALU_RX;
    logic [DW-1:0] ALU_DATA;
    logic          LD_VALID;
    logic          LD_READY;
    logic [AW-1:0] LD_RY;
    logic [DW-1:0] LD_DATA;
    logic [AW-1:0] RX;
    logic [AW-1:0] RY;
    logic          SEL_R;
    logic          WE;
    logic [DW-1:0] WDATA;
    logic          BUSY;

    modport master (
        output ALU_VALID, ALU_RX, ALU_DATA, LD_VALID, LD_RY, LD_DATA,
        input  ALU_READY, LD_READY, RX, RY, SEL_R, WE, WDATA, BUSY
    );

    modport slave (
        input  ALU_VALID, ALU_RX, ALU_DATA, LD_VALID, LD_RY, LD_DATA,
        output ALU_READY, LD_READY, RX, RY, SEL_R, WE, WDATA, BUSY
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back arbiter for the single register-file write port (ALU vs. load).
// Tie policy: WB_RR_ARB_EN defined -> round-robin, undefined -> load has fixed priority.
module wb_port_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    wb_port_arbiter_if.slave bus
);
    // WE is decoded from bit 0 only in practice: every transition keeps it glitch-free
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WR_ALU = 2'b01,
        WR_LD  = 2'b11
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          alu_full;
    logic          ld_full;
    logic [AW-1:0] alu_addr;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] ld_data;
    logic          alu_acc;
    logic          ld_acc;
    logic          grant_alu;
    logic          grant_ld;
    logic          pref_ld;
    logic          alu_full_nxt;
    logic          ld_full_nxt;

`ifdef WB_RR_ARB_EN
    // Last-grant pointer: the state while granting, remembered across IDLE
    logic last_ld;
    logic eff_ld;

    always_comb begin
        eff_ld  = (state == IDLE) ? last_ld : (state == WR_LD);
        pref_ld = ~eff_ld;
    end
`else
    always_comb begin
        pref_ld = 1'b1;
    end
`endif

    // Accept, grant and next-state decode
    always_comb begin
        alu_acc      = bus.ALU_VALID & bus.ALU_READY;
        ld_acc       = bus.LD_VALID & bus.LD_READY;
        grant_ld     = ld_full & (~alu_full | pref_ld);
        grant_alu    = alu_full & ~grant_ld;
        state_nxt    = IDLE;
        if (grant_alu) begin
            state_nxt = WR_ALU;
        end else if (grant_ld) begin
            state_nxt = WR_LD;
        end
        alu_full_nxt = grant_alu ? 1'b0 : (alu_full | alu_acc);
        ld_full_nxt  = grant_ld  ? 1'b0 : (ld_full  | ld_acc);
    end

    assign bus.WE = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= IDLE;
            alu_full      <= 1'b0;
            ld_full       <= 1'b0;
            alu_addr      <= '0;
            ld_addr       <= '0;
            alu_data      <= '0;
            ld_data       <= '0;
            bus.ALU_READY <= 1'b0;
            bus.LD_READY  <= 1'b0;
            bus.RX        <= '0;
            bus.RY        <= '0;
            bus.SEL_R     <= 1'b0;
            bus.WDATA     <= '0;
            bus.BUSY      <= 1'b0;
`ifdef WB_RR_ARB_EN
            last_ld       <= 1'b1;
`endif
        end else begin
            state         <= state_nxt;
            alu_full      <= alu_full_nxt;
            ld_full       <= ld_full_nxt;
            bus.ALU_READY <= ~alu_full_nxt;
            bus.LD_READY  <= ~ld_full_nxt;
            bus.BUSY      <= alu_full_nxt | ld_full_nxt | (state_nxt != IDLE);
`ifdef WB_RR_ARB_EN
            last_ld       <= eff_ld;
`endif
            if (alu_acc) begin
                alu_addr <= bus.ALU_RX;
                alu_data <= bus.ALU_DATA;
            end
            if (ld_acc) begin
                ld_addr <= bus.LD_RY;
                ld_data <= bus.LD_DATA;
            end
            if (grant_alu) begin
                bus.RX    <= alu_addr;
                bus.SEL_R <= 1'b0;
                bus.WDATA <= alu_data;
            end else if (grant_ld) begin
                bus.RY    <= ld_addr;
                bus.SEL_R <= 1'b1;
                bus.WDATA <= ld_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter; a small register-file model
// behind the RZ mux records what the write port commits.
module tb_wb_port_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   alu_cnt;
    int   ld_cnt;
    logic [7:0] rf [8] = '{default: 8'h00};

    wb_port_arbiter_if #(.DW(8), .AW(3)) bus ();

    wb_port_arbiter #(.DW(8), .AW(3)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file behind the RZ mux
    always @(negedge clk) begin
        if (bus.WE === 1'b1) begin
            rf[bus.SEL_R ? bus.RY : bus.RX] <= bus.WDATA;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        alu_cnt       = 0;
        ld_cnt        = 0;
        rst_n         = 1'b0;
        bus.ALU_VALID = 1'b1;
        bus.ALU_RX    = 3'd7;
        bus.ALU_DATA  = 8'hEE;
        bus.LD_VALID  = 1'b1;
        bus.LD_RY     = 3'd6;
        bus.LD_DATA   = 8'hDD;

        // Reset held for three edges with requests pending
        repeat (3) tick();
        check("rst_alu_ready", 32'(bus.ALU_READY), 32'd0);
        check("rst_ld_ready",  32'(bus.LD_READY),  32'd0);
        check("rst_we",        32'(bus.WE),        32'd0);
        check("rst_rx",        32'(bus.RX),        32'd0);
        check("rst_ry",        32'(bus.RY),        32'd0);
        check("rst_sel",       32'(bus.SEL_R),     32'd0);
        check("rst_wdata",     32'(bus.WDATA),     32'd0);
        check("rst_busy",      32'(bus.BUSY),      32'd0);
        bus.ALU_VALID = 1'b0;
        bus.LD_VALID  = 1'b0;
        rst_n         = 1'b1;
        tick();
        check("rel_alu_ready", 32'(bus.ALU_READY), 32'd1);
        check("rel_ld_ready",  32'(bus.LD_READY),  32'd1);
        check("rel_we",        32'(bus.WE),        32'd0);
        check("rel_busy",      32'(bus.BUSY),      32'd0);

        // Single ALU write
        bus.ALU_VALID = 1'b1;
        bus.ALU_RX    = 3'd5;
        bus.ALU_DATA  = 8'hA5;
        tick();
        bus.ALU_VALID = 1'b0;
        check("alu_acc_ready", 32'(bus.ALU_READY), 32'd0);
        check("alu_acc_we",    32'(bus.WE),        32'd0);
        check("alu_acc_busy",  32'(bus.BUSY),      32'd1);
        tick();
        check("alu_we",    32'(bus.WE),        32'd1);
        check("alu_sel",   32'(bus.SEL_R),     32'd0);
        check("alu_rx",    32'(bus.RX),        32'd5);
        check("alu_wdata", 32'(bus.WDATA),     32'hA5);
        check("alu_ready", 32'(bus.ALU_READY), 32'd1);
        tick();
        check("alu_we_off", 32'(bus.WE),   32'd0);
        check("alu_idle",   32'(bus.BUSY), 32'd0);
        check("alu_rf5",    32'(rf[5]),    32'hA5);

        // Single load write
        bus.LD_VALID = 1'b1;
        bus.LD_RY    = 3'd2;
        bus.LD_DATA  = 8'h3C;
        tick();
        bus.LD_VALID = 1'b0;
        check("ld_acc_we", 32'(bus.WE), 32'd0);
        tick();
        check("ld_we",    32'(bus.WE),    32'd1);
        check("ld_sel",   32'(bus.SEL_R), 32'd1);
        check("ld_ry",    32'(bus.RY),    32'd2);
        check("ld_wdata", 32'(bus.WDATA), 32'h3C);
        check("ld_rx",    32'(bus.RX),    32'd5);
        tick();
        check("ld_we_off", 32'(bus.WE), 32'd0);

        // Tie: same destination from both requesters
        bus.ALU_VALID = 1'b1;
        bus.ALU_RX    = 3'd1;
        bus.ALU_DATA  = 8'h11;
        bus.LD_VALID  = 1'b1;
        bus.LD_RY     = 3'd1;
        bus.LD_DATA   = 8'h22;
        tick();
        bus.ALU_VALID = 1'b0;
        bus.LD_VALID  = 1'b0;
        tick();
`ifdef WB_RR_ARB_EN
        check("tie1_sel",   32'(bus.SEL_R), 32'd0);
        check("tie1_wdata", 32'(bus.WDATA), 32'h11);
`else
        check("tie1_sel",   32'(bus.SEL_R), 32'd1);
        check("tie1_wdata", 32'(bus.WDATA), 32'h22);
`endif
        check("tie1_we", 32'(bus.WE), 32'd1);
        tick();
`ifdef WB_RR_ARB_EN
        check("tie2_sel",   32'(bus.SEL_R), 32'd1);
        check("tie2_wdata", 32'(bus.WDATA), 32'h22);
`else
        check("tie2_sel",   32'(bus.SEL_R), 32'd0);
        check("tie2_wdata", 32'(bus.WDATA), 32'h11);
`endif
        check("tie2_we", 32'(bus.WE), 32'd1);
        tick();
        check("tie_we_off", 32'(bus.WE), 32'd0);
`ifdef WB_RR_ARB_EN
        check("tie_rf1", 32'(rf[1]), 32'h22);
`else
        check("tie_rf1", 32'(rf[1]), 32'h11);
`endif

        // Streaming: both requesters continuously valid
        bus.ALU_VALID = 1'b1;
        bus.ALU_RX    = 3'd3;
        bus.ALU_DATA  = 8'h33;
        bus.LD_VALID  = 1'b1;
        bus.LD_RY     = 3'd4;
        bus.LD_DATA   = 8'h44;
        tick();
        tick();
`ifdef WB_RR_ARB_EN
        check("stream_first_sel", 32'(bus.SEL_R), 32'd0);
`else
        check("stream_first_sel", 32'(bus.SEL_R), 32'd1);
`endif
        for (int i = 0; i < 20; i++) begin
            check($sformatf("stream_we_%0d", i), 32'(bus.WE), 32'd1);
            if (bus.SEL_R === 1'b1) ld_cnt++;
            else alu_cnt++;
            if (i < 19) tick();
        end
        check("stream_alu_cnt", 32'(alu_cnt), 32'd10);
        check("stream_ld_cnt",  32'(ld_cnt),  32'd10);
        bus.ALU_VALID = 1'b0;
        bus.LD_VALID  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.BUSY === 1'b0) break;
            tick();
        end
        check("stream_drained", 32'(bus.BUSY), 32'd0);
        check("stream_rf3", 32'(rf[3]), 32'h33);
        check("stream_rf4", 32'(rf[4]), 32'h44);

        // Reset right after both requests are accepted
        bus.ALU_VALID = 1'b1;
        bus.ALU_RX    = 3'd7;
        bus.ALU_DATA  = 8'h77;
        bus.LD_VALID  = 1'b1;
        bus.LD_RY     = 3'd6;
        bus.LD_DATA   = 8'h66;
        tick();
        bus.ALU_VALID = 1'b0;
        bus.LD_VALID  = 1'b0;
        check("mid_busy", 32'(bus.BUSY), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_we",    32'(bus.WE),        32'd0);
        check("mid_rst_ready", 32'(bus.ALU_READY), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_alu_ready", 32'(bus.ALU_READY), 32'd1);
        check("mid_rel_ld_ready",  32'(bus.LD_READY),  32'd1);
        check("mid_rel_we",        32'(bus.WE),        32'd0);
        tick();
        check("mid_post_we",   32'(bus.WE),   32'd0);
        check("mid_post_busy", 32'(bus.BUSY), 32'd0);
        tick();
        check("mid_rf7", 32'(rf[7]), 32'h00);
        check("mid_rf6", 32'(rf[6]), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
